// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing constants, helpers and types for the VGA sync generator.
//   CNT_W          - width of the pixel/line counters (10 bits, totals up to 1024)
//   *_DEF          - default 640x480@60 timing
//   sync_pol_e     - asserted level of hsync/vsync
//   axis_total/h_total/v_total - derived period of one axis
//   bar_rgb        - 8-bar test pattern colour for a visible x coordinate
`timescale 1ns/1ps
package vga_timing_pkg;
  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  // Bar index 0..7 across the visible width; idx bits map straight onto R/G/B.
  function automatic logic [23:0] bar_rgb(input logic [CNT_W-1:0] x, input int bar_w);
    int         idx;
    logic [2:0] b;
    idx = int'(x) / bar_w;
    b   = idx[2:0];
    return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing/coordinate bundle from the sync generator to the pixel stage.
//   master - driven by vga_sync_gen
//   slave  - consumed by the colour stage / port wrapper
//   coe_red/green/blue exist only with VGA_SYNC_GEN_TESTPAT_EN defined.
`timescale 1ns/1ps
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             pix_ce;
  logic             coe_hsync;
  logic             coe_vsync;
  logic             pix_active;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_SYNC_GEN_TESTPAT_EN
  logic [7:0]       coe_red;
  logic [7:0]       coe_green;
  logic [7:0]       coe_blue;

  modport master (output pix_ce, coe_hsync, coe_vsync, pix_active, pix_x, pix_y,
                         line_start, frame_start, coe_red, coe_green, coe_blue);
  modport slave  (input  pix_ce, coe_hsync, coe_vsync, pix_active, pix_x, pix_y,
                         line_start, frame_start, coe_red, coe_green, coe_blue);
`else
  modport master (output pix_ce, coe_hsync, coe_vsync, pix_active, pix_x, pix_y,
                         line_start, frame_start);
  modport slave  (input  pix_ce, coe_hsync, coe_vsync, pix_active, pix_x, pix_y,
                         line_start, frame_start);
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
//   clk, rst_n - clock, async active-low reset
//   en         - advance this edge
//   count      - current position, resets to TOTAL-1 so the first advance lands on 0
//   active_d   - position after this edge lies in the visible region (combinational)
//   sync       - registered sync level (POL when asserted)
//   wrap       - count is at TOTAL-1 (combinational)
`timescale 1ns/1ps
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int        ACTIVE = H_ACTIVE_DEF,
  parameter int        FP     = H_FP_DEF,
  parameter int        SYNC   = H_SYNC_DEF,
  parameter int        BP     = H_BP_DEF,
  parameter sync_pol_e POL    = SYNC_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             active_d,
  output logic             sync,
  output logic             wrap
);
  localparam int               TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic             ASSERTED = logic'(POL);

  logic [CNT_W-1:0] cnt_d;
  logic             in_sync;

  assign wrap = (count == LAST);

  always_comb begin
    cnt_d = count;
    if (en) cnt_d = wrap ? '0 : count + 1'b1;
  end

  // Decode from the value being loaded so flags line up with count.
  assign active_d = (cnt_d < ACT_END);
  assign in_sync  = (cnt_d >= SYNC_BEG) && (cnt_d < SYNC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LAST;
      sync  <= ~ASSERTED;
    end else begin
      count <= cnt_d;
      sync  <= in_sync ? ASSERTED : ~ASSERTED;
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing from the 50 MHz clock using a /2 pixel enable.
//   csi_clk50   - 50 MHz system clock (only clock)
//   csi_reset_n - async active-low reset
//   vga         - master modport: pix_ce, coe_hsync, coe_vsync, pix_active, pix_x, pix_y,
//                 line_start, frame_start (+ coe_red/green/blue with VGA_SYNC_GEN_TESTPAT_EN)
// Every output is a register loaded on pix_ce edges, so all of them hold for two clocks
// and stay mutually aligned. Define VGA_SYNC_GEN_TESTPAT_EN for an 8-bar colour pattern.
`timescale 1ns/1ps
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           csi_clk50,
  input  logic           csi_reset_n,
  vga_sync_gen_if.master vga
);
  localparam sync_pol_e POL = SYNC_POL ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;

  if (h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) > MAX_TOTAL ||
      v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) > MAX_TOTAL) begin : g_bad_timing
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end

  logic             ce;
  logic             v_en;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_act_d, v_act_d;
  logic             h_wrap, v_wrap;
  logic             hsync, vsync;
  logic             pix_active, line_start, frame_start;

  // Toggle from 0: high in the 1st, 3rd, ... cycle after reset release.
  always_ff @(posedge csi_clk50 or negedge csi_reset_n) begin
    if (!csi_reset_n) ce <= 1'b0;
    else              ce <= ~ce;
  end

  assign v_en = ce & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(POL)
  ) u_h (
    .clk(csi_clk50), .rst_n(csi_reset_n), .en(ce),
    .count(h_cnt), .active_d(h_act_d), .sync(hsync), .wrap(h_wrap)
  );

  // Vertical steps at the horizontal wrap, so vsync changes at h = 0.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(POL)
  ) u_v (
    .clk(csi_clk50), .rst_n(csi_reset_n), .en(v_en),
    .count(v_cnt), .active_d(v_act_d), .sync(vsync), .wrap(v_wrap)
  );

  // Next x is 0 exactly when the current x wraps; same for the frame origin.
  always_ff @(posedge csi_clk50 or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      pix_active  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      pix_active  <= h_act_d & v_act_d;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

  assign vga.pix_ce      = ce;
  assign vga.coe_hsync   = hsync;
  assign vga.coe_vsync   = vsync;
  assign vga.pix_active  = pix_active;
  assign vga.pix_x       = h_cnt;
  assign vga.pix_y       = v_cnt;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;

`ifdef VGA_SYNC_GEN_TESTPAT_EN
  logic [CNT_W-1:0] x_nxt;
  logic [23:0]      rgb;

  assign x_nxt = h_wrap ? '0 : h_cnt + 1'b1;

  always_ff @(posedge csi_clk50 or negedge csi_reset_n) begin
    if (!csi_reset_n)  rgb <= '0;
    else if (ce)       rgb <= (h_act_d & v_act_d) ? bar_rgb(x_nxt, H_ACTIVE / 8) : '0;
  end

  assign vga.coe_red   = rgb[23:16];
  assign vga.coe_green = rgb[15:8];
  assign vga.coe_blue  = rgb[7:0];
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench. Horizontal timing is the real 800-pixel line;
// vertical timing is shrunk (4/1/2/1 = 8 lines) so full frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int VT = 8;

  typedef struct {
    int          k;     // pixel index since release; -1 = sample while in reset
    logic [9:0]  x, y;
    logic        act, hs, vs, ls, fs;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   e = 0;
  int   n_chk = 0, n_fail = 0;
  int   hs_lo = 0, act_hi = 0;
  bit   found;
  exp_t q[$];

  vga_sync_gen_if vif();

  vga_sync_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut (
    .csi_clk50(clk), .csi_reset_n(rst_n), .vga(vif)
  );

  always #10 clk = ~clk;

  // Clock edges since reset release.
  always @(posedge clk) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(int k, int x, int y, bit act, bit hs, bit vs, bit ls, bit fs,
                              logic [23:0] rgb = 24'h0);
    exp_t r;
    r.k = k; r.x = 10'(x); r.y = 10'(y);
    r.act = act; r.hs = hs; r.vs = vs; r.ls = ls; r.fs = fs; r.rgb = rgb;
    return r;
  endfunction

  task automatic push_reset();
    q.push_back(mk(-1, 799, VT - 1, 0, 1, 1, 0, 0));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk("scoreboard_drain_pending", q.size(), 0);
      q.delete();
    end
  endtask

  // Monitor: pixel k is presented after edge 2k+2 since release.
  always @(negedge clk) begin
    exp_t r;
    bit   take;
    if (rst_n && e >= 1) chk("pix_ce_phase", 32'(vif.pix_ce), 32'(e[0]));

    if (!rst_n) begin
      hs_lo = 0; act_hi = 0;
    end else if (e >= 2 && e <= 1601) begin
      hs_lo  += int'(vif.coe_hsync == 1'b0);
      act_hi += int'(vif.pix_active);
      if (e == 1601) begin
        chk("hsync_low_clks_line0", hs_lo, 192);
        chk("active_clks_line0", act_hi, 1280);
      end
    end

    if (q.size() > 0) begin
      r = q[0];
      take = (r.k < 0) ? !rst_n : (rst_n && e >= 2 && !e[0] && (e - 2) / 2 == r.k);
      if (take) begin
        void'(q.pop_front());
        chk($sformatf("pix_x@%0d", r.k),       vif.pix_x,       r.x);
        chk($sformatf("pix_y@%0d", r.k),       vif.pix_y,       r.y);
        chk($sformatf("pix_active@%0d", r.k),  vif.pix_active,  r.act);
        chk($sformatf("hsync@%0d", r.k),       vif.coe_hsync,   r.hs);
        chk($sformatf("vsync@%0d", r.k),       vif.coe_vsync,   r.vs);
        chk($sformatf("line_start@%0d", r.k),  vif.line_start,  r.ls);
        chk($sformatf("frame_start@%0d", r.k), vif.frame_start, r.fs);
`ifdef VGA_SYNC_GEN_TESTPAT_EN
        chk($sformatf("rgb@%0d", r.k), {vif.coe_red, vif.coe_green, vif.coe_blue}, r.rgb);
`endif
      end
    end
  end

  initial begin
    push_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    //             k     x    y  act hs vs ls fs
    q.push_back(mk(0,    0,   0, 1,  1, 1, 1, 1));
    q.push_back(mk(1,    1,   0, 1,  1, 1, 0, 0));
    q.push_back(mk(85,   85,  0, 1,  1, 1, 0, 0, 24'h0000FF));
    q.push_back(mk(600,  600, 0, 1,  1, 1, 0, 0, 24'hFFFFFF));
    q.push_back(mk(639,  639, 0, 1,  1, 1, 0, 0, 24'hFFFFFF));
    q.push_back(mk(640,  640, 0, 0,  1, 1, 0, 0));
    q.push_back(mk(655,  655, 0, 0,  1, 1, 0, 0));
    q.push_back(mk(656,  656, 0, 0,  0, 1, 0, 0));
    q.push_back(mk(700,  700, 0, 0,  0, 1, 0, 0));
    q.push_back(mk(751,  751, 0, 0,  0, 1, 0, 0));
    q.push_back(mk(752,  752, 0, 0,  1, 1, 0, 0));
    q.push_back(mk(799,  799, 0, 0,  1, 1, 0, 0));
    q.push_back(mk(800,  0,   1, 1,  1, 1, 1, 0));
    q.push_back(mk(2400, 0,   3, 1,  1, 1, 1, 0));
    q.push_back(mk(3199, 799, 3, 0,  1, 1, 0, 0));
    q.push_back(mk(3200, 0,   4, 0,  1, 1, 1, 0));
    q.push_back(mk(3999, 799, 4, 0,  1, 1, 0, 0));
    q.push_back(mk(4000, 0,   5, 0,  1, 0, 1, 0));
    q.push_back(mk(5599, 799, 6, 0,  1, 0, 0, 0));
    q.push_back(mk(5600, 0,   7, 0,  1, 1, 1, 0));
    q.push_back(mk(6399, 799, 7, 0,  1, 1, 0, 0));
    q.push_back(mk(6400, 0,   0, 1,  1, 1, 1, 1));
    q.push_back(mk(7056, 656, 0, 0,  0, 1, 0, 0));
    q.push_back(mk(7100, 700, 0, 0,  0, 1, 0, 0));
    drain(16000);

    // Reset in the middle of an hsync pulse; sampled before the next clock edge.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (vif.pix_x == 10'd700) found = 1'b1;
    end
    if (!found) chk("reach_pix_x_700", vif.pix_x, 700);
    @(posedge clk);
    #1;
    push_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    q.push_back(mk(0,   0,   0, 1, 1, 1, 1, 1));
    q.push_back(mk(1,   1,   0, 1, 1, 1, 0, 0));
    q.push_back(mk(656, 656, 0, 0, 0, 1, 0, 0));
    q.push_back(mk(700, 700, 0, 0, 0, 1, 0, 0));
    q.push_back(mk(800, 0,   1, 1, 1, 1, 1, 0));
    drain(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
